ctrl_seq: RTL and testbench

- Microsequencer for the 8-bit CPU. Steps the machine through fetch (T1-T3) and execute (T4-T6) states.
- Decodes the 4-bit opcode from the instruction register (ir_ins) into one-hot control strobes for PC, MAR, RAM, IR, accumulator, B register, ALU and output register.
- Guarantees a single bus driver per cycle and provides run, single-step and halt control.

---
 rtl/ctrl_seq.sv | 126 ++++++++++++
 tb/tb_ctrl_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_seq.sv
// Microsequencer for the 8-bit CPU: steps fetch (T1-T3) and execute (T4-T6)
// T-states and decodes the IR opcode into one-hot datapath control strobes.
module ctrl_seq #(
  parameter bit         EARLY_END = 1'b1,
  parameter logic [3:0] OP_LDA    = 4'h0,
  parameter logic [3:0] OP_ADD    = 4'h1,
  parameter logic [3:0] OP_SUB    = 4'h2,
  parameter logic [3:0] OP_OUT    = 4'hE,
  parameter logic [3:0] OP_HLT    = 4'hF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic [3:0] ir_ins,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ir_in,
  output logic       ir_out,
  output logic       acc_in,
  output logic       acc_out,
  output logic       b_in,
  output logic       alu_sub,
  output logic       alu_out,
  output logic       out_in,
  output logic [2:0] t_state,
  output logic       instr_done,
  output logic       halted
);

  // state | meaning
  // IDLE  | waiting for run or a step pulse
  // T1-T3 | fetch: PC->MAR, PC++, RAM->IR
  // T4-T6 | execute, microcode selected by ir_ins
  // HALT  | absorbing after HLT; only reset leaves
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T1   = 3'd1;
  localparam logic [2:0] S_T2   = 3'd2;
  localparam logic [2:0] S_T3   = 3'd3;
  localparam logic [2:0] S_T4   = 3'd4;
  localparam logic [2:0] S_T5   = 3'd5;
  localparam logic [2:0] S_T6   = 3'd6;
  localparam logic [2:0] S_HALT = 3'd7;

  logic [2:0] state_q, state_d;
  logic       is_lda, is_add, is_sub, is_out, is_hlt, is_nop;
  logic       last_st;

  always_comb begin
    is_lda  = (ir_ins == OP_LDA);
    is_add  = (ir_ins == OP_ADD);
    is_sub  = (ir_ins == OP_SUB);
    is_out  = (ir_ins == OP_OUT);
    is_hlt  = (ir_ins == OP_HLT);
    is_nop  = !(is_lda || is_add || is_sub || is_out || is_hlt);
    // NOP's early exit at T3 is the only place the fetch states look at ir_ins
    case (state_q)
      S_T3:    last_st = EARLY_END && is_nop;
      S_T4:    last_st = EARLY_END && is_out;
      S_T5:    last_st = EARLY_END && is_lda;
      S_T6:    last_st = 1'b1;
      default: last_st = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (run || step) state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_HALT: state_d = S_HALT;
      default: begin
        if (state_q == S_T4 && is_hlt) state_d = S_HALT;
        else if (last_st)              state_d = run ? S_T1 : S_IDLE;
        else                           state_d = state_q + 3'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    pc_out  = 1'b0;
    pc_inc  = 1'b0;
    mar_in  = 1'b0;
    ram_out = 1'b0;
    ir_in   = 1'b0;
    ir_out  = 1'b0;
    acc_in  = 1'b0;
    acc_out = 1'b0;
    b_in    = 1'b0;
    alu_sub = 1'b0;
    alu_out = 1'b0;
    out_in  = 1'b0;
    case (state_q)
      S_T1: begin pc_out = 1'b1; mar_in = 1'b1; end
      S_T2: pc_inc = 1'b1;
      S_T3: begin ram_out = 1'b1; ir_in = 1'b1; end
      S_T4: begin
        if (is_lda || is_add || is_sub) begin ir_out = 1'b1; mar_in = 1'b1; end
        if (is_out) begin acc_out = 1'b1; out_in = 1'b1; end
      end
      S_T5: begin
        if (is_lda) begin ram_out = 1'b1; acc_in = 1'b1; end
        if (is_add || is_sub) begin ram_out = 1'b1; b_in = 1'b1; end
        alu_sub = is_sub;
      end
      S_T6: begin
        if (is_add || is_sub) begin alu_out = 1'b1; acc_in = 1'b1; end
        alu_sub = is_sub;
      end
      default: ;
    endcase
  end

  assign t_state    = state_q;
  assign instr_done = last_st;
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: one DUT per EARLY_END setting, checked every cycle against
// an instruction-length/microcode-table model, plus directed literal checks.
module tb_ctrl_seq;

  localparam logic [11:0] M_PC_OUT  = 12'h800;
  localparam logic [11:0] M_PC_INC  = 12'h400;
  localparam logic [11:0] M_MAR_IN  = 12'h200;
  localparam logic [11:0] M_RAM_OUT = 12'h100;
  localparam logic [11:0] M_IR_IN   = 12'h080;
  localparam logic [11:0] M_IR_OUT  = 12'h040;
  localparam logic [11:0] M_ACC_IN  = 12'h020;
  localparam logic [11:0] M_ACC_OUT = 12'h010;
  localparam logic [11:0] M_B_IN    = 12'h008;
  localparam logic [11:0] M_ALU_SUB = 12'h004;
  localparam logic [11:0] M_ALU_OUT = 12'h002;
  localparam logic [11:0] M_OUT_IN  = 12'h001;
  localparam logic [11:0] M_DRV     = 12'h952;

  logic       clk = 1'b0;
  logic       rst_n, run, step;
  logic [3:0] ir1, ir0, op1, op0;
  wire  [11:0] st1, st0;
  wire  [2:0]  t1, t0;
  wire         d1, d0, h1, h0;

  int errors = 0;
  int checks = 0;
  int mt1 = 0;
  int mt0 = 0;
  int force_op = -1;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  ctrl_seq #(.EARLY_END(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .ir_ins(ir1),
    .pc_out(st1[11]), .pc_inc(st1[10]), .mar_in(st1[9]), .ram_out(st1[8]),
    .ir_in(st1[7]), .ir_out(st1[6]), .acc_in(st1[5]), .acc_out(st1[4]),
    .b_in(st1[3]), .alu_sub(st1[2]), .alu_out(st1[1]), .out_in(st1[0]),
    .t_state(t1), .instr_done(d1), .halted(h1));

  ctrl_seq #(.EARLY_END(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .run(run), .step(step), .ir_ins(ir0),
    .pc_out(st0[11]), .pc_inc(st0[10]), .mar_in(st0[9]), .ram_out(st0[8]),
    .ir_in(st0[7]), .ir_out(st0[6]), .acc_in(st0[5]), .acc_out(st0[4]),
    .b_in(st0[3]), .alu_sub(st0[2]), .alu_out(st0[1]), .out_in(st0[0]),
    .t_state(t0), .instr_done(d0), .halted(h0));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Final T-state of an instruction; HLT never finishes (returns 99).
  function automatic int last_t(input int op, input bit early);
    if (op == 15) return 99;
    if (!early) return 6;
    case (op)
      0:       return 5;
      1, 2:    return 6;
      14:      return 4;
      default: return 3;
    endcase
  endfunction

  function automatic int next_t(input int t, input int op, input bit r, input bit s, input bit early);
    if (t == 0) return (r || s) ? 1 : 0;
    if (t == 7) return 7;
    if (t == 4 && op == 15) return 7;
    if (t == last_t(op, early)) return r ? 1 : 0;
    return t + 1;
  endfunction

  function automatic logic [11:0] exp_str(input int t, input int op);
    case (t)
      1: return M_PC_OUT | M_MAR_IN;
      2: return M_PC_INC;
      3: return M_RAM_OUT | M_IR_IN;
      4: if (op <= 2) return M_IR_OUT | M_MAR_IN;
         else if (op == 14) return M_ACC_OUT | M_OUT_IN;
      5: if (op == 0) return M_RAM_OUT | M_ACC_IN;
         else if (op == 1) return M_RAM_OUT | M_B_IN;
         else if (op == 2) return M_RAM_OUT | M_B_IN | M_ALU_SUB;
      6: if (op == 1) return M_ALU_OUT | M_ACC_IN;
         else if (op == 2) return M_ALU_OUT | M_ACC_IN | M_ALU_SUB;
      default: ;
    endcase
    return 12'h000;
  endfunction

  function automatic int exp_done(input int t, input int op, input bit early);
    return (t >= 1 && t <= 6 && t == last_t(op, early)) ? 1 : 0;
  endfunction

  function automatic logic [3:0] pick();
    if (force_op >= 0) return 4'(force_op);
    case ($urandom_range(0, 7))
      0: return 4'h0;
      1: return 4'h1;
      2: return 4'h2;
      3: return 4'hE;
      default: return 4'($urandom_range(3, 13));
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("t_state1", int'(t1), mt1);
      chk("strobes1", int'(st1), int'(exp_str(mt1, int'(ir1))));
      chk("done1", int'(d1), exp_done(mt1, int'(ir1), 1'b1));
      chk("halted1", int'(h1), (mt1 == 7) ? 1 : 0);
      chk("onebus1", ($countones(st1 & M_DRV) <= 1) ? 1 : 0, 1);
      chk("marram1", int'(st1[9] & st1[8]), 0);
      chk("t_state0", int'(t0), mt0);
      chk("strobes0", int'(st0), int'(exp_str(mt0, int'(ir0))));
      chk("done0", int'(d0), exp_done(mt0, int'(ir0), 1'b0));
      chk("halted0", int'(h0), (mt0 == 7) ? 1 : 0);
      chk("onebus0", ($countones(st0 & M_DRV) <= 1) ? 1 : 0, 1);
      chk("marram0", int'(st0[9] & st0[8]), 0);
    end
  end

  // Advance one clock: update the model from inputs seen at the edge, then
  // drive ir: garbage during fetch/idle, the chosen opcode from T3 onward.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mt1 = 0;
      mt0 = 0;
    end else begin
      mt1 = next_t(mt1, int'(ir1), run, step, 1'b1);
      mt0 = next_t(mt0, int'(ir0), run, step, 1'b0);
    end
    if (mt1 == 3) op1 = pick();
    if (mt0 == 3) op0 = pick();
    ir1 = (mt1 >= 3 && mt1 <= 6) ? op1 : 4'($urandom);
    ir0 = (mt0 >= 3 && mt0 <= 6) ? op0 : 4'($urandom);
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic wait_t1(input int target, input string nm);
    int n = 0;
    while (int'(t1) != target && n < 40) begin
      tick();
      n++;
    end
    chk(nm, int'(t1), target);
  endtask

  int exp_lda[6] = '{1, 2, 3, 4, 5, 1};
  int exp_sub[6] = '{2, 3, 4, 5, 6, 0};
  int exp_asb[6] = '{0, 0, 0, 1, 1, 0};
  int exp_stp[5] = '{2, 3, 4, 0, 0};
  int exp_n1[6]  = '{2, 3, 0, 0, 0, 0};
  int exp_n0[6]  = '{2, 3, 4, 5, 6, 0};

  initial begin
    rst_n = 1'b0; run = 1'b0; step = 1'b0;
    ir1 = 4'h0; ir0 = 4'h0; op1 = 4'h0; op0 = 4'h0;
    #2 chk_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    sample();
    chk("rst_t", int'(t1), 0);
    chk("rst_str", int'(st1), 0);
    chk("rst_halt", int'(h1), 0);

    // reset in the middle of ADD T5
    run = 1'b1; force_op = 1;
    wait_t1(5, "add_reach_t5");
    #2 rst_n = 1'b0; mt1 = 0; mt0 = 0;
    #1;
    chk("async_rst_t", int'(t1), 0);
    chk("async_rst_str", int'(st1), 0);
    chk("async_rst_done", int'(d1), 0);
    run = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); sample();
      chk("idle_after_rst", int'(t1), 0);
    end

    // LDA free-running
    force_op = 0; run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(); sample();
      chk("lda_t", int'(t1), exp_lda[i]);
      chk("lda_done", int'(d1), (i == 4) ? 1 : 0);
      if (i == 3) chk("lda_t4_str", int'(st1), int'(M_IR_OUT | M_MAR_IN));
      if (i == 4) chk("lda_t5_str", int'(st1), int'(M_RAM_OUT | M_ACC_IN));
    end

    // SUB, with run dropped mid-instruction
    force_op = 2; run = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(); sample();
      chk("sub_t", int'(t1), exp_sub[i]);
      chk("sub_alu_sub", int'(st1[2]), exp_asb[i]);
      if (i == 4) chk("sub_t6_str", int'(st1), int'(M_ALU_OUT | M_ACC_IN | M_ALU_SUB));
    end

    // single step of OUT, second step mid-instruction ignored
    force_op = 14;
    step = 1'b1; tick(); step = 1'b0; sample();
    chk("step_t1", int'(t1), 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) step = 1'b1;
      tick(); step = 1'b0; sample();
      chk("step_t", int'(t1), exp_stp[i]);
      if (i == 2) begin
        chk("out_t4_str", int'(st1), int'(M_ACC_OUT | M_OUT_IN));
        chk("out_done", int'(d1), 1);
      end
    end

    // undefined opcode, both EARLY_END settings
    begin
      int n = 0;
      while ((t1 != 3'd0 || t0 != 3'd0) && n < 20) begin tick(); n++; end
      chk("both_idle", int'(t1) + int'(t0), 0);
    end
    force_op = 7;
    step = 1'b1; tick(); step = 1'b0; sample();
    chk("nop_start1", int'(t1), 1);
    chk("nop_start0", int'(t0), 1);
    for (int i = 0; i < 6; i++) begin
      tick(); sample();
      chk("nop1_t", int'(t1), exp_n1[i]);
      chk("nop0_t", int'(t0), exp_n0[i]);
      chk("nop1_done", int'(d1), (i == 1) ? 1 : 0);
      chk("nop0_done", int'(d0), (i == 4) ? 1 : 0);
      if (i >= 2 && i <= 4) chk("nop0_str", int'(st0), 0);
    end

    // HLT is absorbing
    force_op = 15; run = 1'b1;
    wait_t1(7, "hlt_enter");
    chk("hlt_enter0", int'(t0), 7);
    for (int i = 0; i < 10; i++) begin
      step = i[0];
      tick(); step = 1'b0; sample();
      chk("hlt_t", int'(t1), 7);
      chk("hlt_flag", int'(h1), 1);
      chk("hlt_str", int'(st1), 0);
    end
    #2 rst_n = 1'b0; mt1 = 0; mt0 = 0;
    #1;
    chk("hlt_rst_t", int'(t1), 0);
    chk("hlt_rst_flag", int'(h1), 0);
    run = 1'b0; force_op = -1;
    tick();
    rst_n = 1'b1;

    // randomized run/step/reset traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      step = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0; mt1 = 0; mt0 = 0;
      end
      tick();
      if (!rst_n) rst_n = 1'b1;
    end
    sample();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
